imem_loader: RTL

- Boot-time program loader and the writer side of the pipelined CPU's instruction memory.
- Receives a byte stream over a valid/ready handshake and assembles it into 32-bit instruction words, big-endian, first byte = bits [31:24].
- Clears instruction memory, writes the program, clears data memory, then releases the CPU from reset.
- Sits between the board/bench byte source and the CPU's IM/DM write ports and reset input.

---
 rtl/loader_pkg.sv | 18 +
 rtl/byte_packer.sv | 47 ++++
 rtl/imem_loader.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader:
// sequencer state encoding, default memory geometry and word packing constants.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR_IM,
    ST_LOAD,
    ST_CLR_DM,
    ST_RUN
  } state_t;

  localparam int IM_DEPTH_DEF   = 32;
  localparam int DM_DEPTH_DEF   = 128;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_BITS      = 8 * BYTES_PER_WORD;

endpackage : loader_pkg

// File: rtl/byte_packer.sv
// Assembles a big-endian byte stream into 32-bit words; the first byte of a
// word lands in bits [31:24]. o_word_valid pulses the cycle after the last byte.
module byte_packer
  import loader_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 i_clr,
  input  logic                 i_valid,
  input  logic [7:0]           i_data,
  output logic                 o_last,
  output logic [WORD_BITS-1:0] o_word,
  output logic                 o_word_valid
);

  localparam logic [1:0] LP_LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [1:0]           r_idx;
  logic [WORD_BITS-1:0] r_shift;
  logic                 r_word_valid;

  // High when the byte offered this cycle would complete the current word.
  assign o_last       = (r_idx == LP_LAST_IDX);
  assign o_word       = r_shift;
  assign o_word_valid = r_word_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_idx        <= '0;
      r_shift      <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_clr) begin
        r_idx   <= '0;
        r_shift <= '0;
      end else if (i_valid) begin
        r_shift      <= {r_shift[WORD_BITS-9:0], i_data};
        r_idx        <= r_idx + 2'd1;
        r_word_valid <= (r_idx == LP_LAST_IDX);
      end
    end
  end

endmodule : byte_packer

// File: rtl/imem_loader.sv
// Boot loader: clears instruction memory, streams the program into it, clears
// data memory, then releases the CPU from reset. All outputs are registered.
module imem_loader
  import loader_pkg::*;
#(
  parameter int IM_DEPTH = IM_DEPTH_DEF,
  parameter int IM_AW    = 5,
  parameter int DM_DEPTH = DM_DEPTH_DEF,
  parameter int DM_AW    = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [IM_AW:0]   word_count_i,
  input  logic [7:0]       byte_data_i,
  input  logic             byte_valid_i,
  output logic             byte_ready_o,
  output logic             im_we_o,
  output logic [IM_AW-1:0] im_waddr_o,
  output logic [31:0]      im_wdata_o,
  output logic             dm_we_o,
  output logic [DM_AW-1:0] dm_waddr_o,
  output logic [7:0]       dm_wdata_o,
  output logic             cpu_rst_n_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam logic [IM_AW:0]   LP_IM_MAX  = (IM_AW + 1)'(IM_DEPTH);
  localparam logic [IM_AW:0]   LP_W_ONE   = (IM_AW + 1)'(1);
  localparam logic [IM_AW-1:0] LP_IM_LAST = IM_AW'(IM_DEPTH - 1);
  localparam logic [IM_AW-1:0] LP_IM_ONE  = IM_AW'(1);
  localparam logic [DM_AW-1:0] LP_DM_LAST = DM_AW'(DM_DEPTH - 1);
  localparam logic [DM_AW-1:0] LP_DM_ONE  = DM_AW'(1);

  state_t           r_state;
  logic [IM_AW:0]   r_word_total;
  logic [IM_AW:0]   r_word_cnt;
  logic [IM_AW-1:0] r_wr_idx;
  logic [IM_AW-1:0] r_im_clr;
  logic [DM_AW-1:0] r_dm_clr;
  logic             r_ready;
  logic             r_im_we;
  logic [IM_AW-1:0] r_im_waddr;
  logic [31:0]      r_im_wdata;
  logic             r_dm_we;
  logic [DM_AW-1:0] r_dm_waddr;
  logic             r_cpu_rst_n;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_accept;
  logic             w_last_byte;
  logic             w_word_valid;
  logic [31:0]      w_word;
  logic             w_can_start;
  logic             w_start_ok;
  logic             w_start_bad;

  assign w_accept    = byte_valid_i && r_ready;
  assign w_can_start = (r_state == ST_IDLE) || (r_state == ST_RUN);
  assign w_start_ok  = w_can_start && start_i && (word_count_i <= LP_IM_MAX);
  assign w_start_bad = w_can_start && start_i && (word_count_i > LP_IM_MAX);

  byte_packer u_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .i_clr        (w_start_ok),
    .i_valid      (w_accept),
    .i_data       (byte_data_i),
    .o_last       (w_last_byte),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= ST_IDLE;
      r_word_total <= '0;
      r_word_cnt   <= '0;
      r_wr_idx     <= '0;
      r_im_clr     <= '0;
      r_dm_clr     <= '0;
      r_ready      <= 1'b0;
      r_im_we      <= 1'b0;
      r_im_waddr   <= '0;
      r_im_wdata   <= '0;
      r_dm_we      <= 1'b0;
      r_dm_waddr   <= '0;
      r_cpu_rst_n  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      // Write ports idle at zero unless a state below drives them this cycle.
      r_im_we    <= 1'b0;
      r_im_waddr <= '0;
      r_im_wdata <= '0;
      r_dm_we    <= 1'b0;
      r_dm_waddr <= '0;

      // A completed word is written one cycle after its last byte, which may
      // already fall in the first data-memory clear cycle.
      if (w_word_valid) begin
        r_im_we    <= 1'b1;
        r_im_waddr <= r_wr_idx;
        r_im_wdata <= w_word;
        r_wr_idx   <= r_wr_idx + LP_IM_ONE;
      end

      unique case (r_state)
        ST_IDLE, ST_RUN: begin
          if (w_start_ok) begin
            r_state      <= ST_CLR_IM;
            r_word_total <= word_count_i;
            r_word_cnt   <= '0;
            r_wr_idx     <= '0;
            r_im_clr     <= '0;
            r_err        <= 1'b0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_cpu_rst_n  <= 1'b0;
          end else begin
            if (w_start_bad) r_err <= 1'b1;
            if (r_state == ST_RUN) begin
              r_cpu_rst_n <= 1'b1;
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
            end
          end
        end

        ST_CLR_IM: begin
          r_im_we    <= 1'b1;
          r_im_waddr <= r_im_clr;
          r_im_wdata <= '0;
          r_im_clr   <= r_im_clr + LP_IM_ONE;
          if (r_im_clr == LP_IM_LAST) begin
            if (r_word_total == '0) begin
              r_state  <= ST_CLR_DM;
              r_dm_clr <= '0;
            end else begin
              r_state <= ST_LOAD;
              r_ready <= 1'b1;
            end
          end
        end

        ST_LOAD: begin
          if (w_accept && w_last_byte) begin
            r_word_cnt <= r_word_cnt + LP_W_ONE;
            if ((r_word_cnt + LP_W_ONE) == r_word_total) begin
              r_state  <= ST_CLR_DM;
              r_ready  <= 1'b0;
              r_dm_clr <= '0;
            end
          end
        end

        ST_CLR_DM: begin
          r_dm_we    <= 1'b1;
          r_dm_waddr <= r_dm_clr;
          r_dm_clr   <= r_dm_clr + LP_DM_ONE;
          if (r_dm_clr == LP_DM_LAST) r_state <= ST_RUN;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign byte_ready_o = r_ready;
  assign im_we_o      = r_im_we;
  assign im_waddr_o   = r_im_waddr;
  assign im_wdata_o   = r_im_wdata;
  assign dm_we_o      = r_dm_we;
  assign dm_waddr_o   = r_dm_waddr;
  assign dm_wdata_o   = '0;
  assign cpu_rst_n_o  = r_cpu_rst_n;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign err_o        = r_err;

endmodule : imem_loader
